// File: rtl/paced_queue_reader.sv
// ---------------------------------------------------------------------------
// paced_queue_reader
//
// Consumer end of the sample queue. The producer pushes DATA_W-bit samples
// into a circular buffer; the block pops them at a fixed pace of at most one
// pop per INTERVAL cycles. Each popped sample is held on a valid/ready output
// until downstream accepts it. Backpressure stretches the pace and never
// drops stored data.
//
// Ports:
//   clk        single clock, all state updates on the rising edge
//   rst        asynchronous, active-high reset
//   wr_en      producer push strobe
//   wr_data    sample to push
//   wr_full    high while the buffer holds DEPTH samples
//   rx_valid   a popped sample is held on rx_data
//   rx_data    popped sample
//   rx_ready   downstream accepts rx_data
//   count      current buffer occupancy (registered)
//   overflow   one-cycle pulse, a push was dropped because the buffer was full
//   underflow  one-cycle pulse, a pop slot found the buffer empty
// ---------------------------------------------------------------------------
module paced_queue_reader #(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 16,
   parameter int INTERVAL = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [DATA_W-1:0]          wr_data,
   output logic                       wr_full,
   output logic                       rx_valid,
   output logic [DATA_W-1:0]          rx_data,
   input  logic                       rx_ready,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int PCNT_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;

   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
   localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(INTERVAL - 1);

   typedef enum logic {
      ST_WAIT,
      ST_PRESENT
   } state_t;

   logic [DATA_W-1:0] mem [DEPTH];

   state_t            state_q,     state_d;
   logic [PTR_W-1:0]  rptr_q,      rptr_d;
   logic [PTR_W-1:0]  wptr_q,      wptr_d;
   logic [PCNT_W-1:0] pcnt_q,      pcnt_d;
   logic [CNT_W-1:0]  count_q,     count_d;
   logic              rx_valid_q,  rx_valid_d;
   logic [DATA_W-1:0] rx_data_q,   rx_data_d;
   logic              overflow_q,  overflow_d;
   logic              underflow_q, underflow_d;

   logic              full;
   logic              push_ok;
   logic              pop;

   assign full      = (count_q == CNT_FULL);
   assign wr_full   = full;
   assign rx_valid  = rx_valid_q;
   assign rx_data   = rx_data_q;
   assign count     = count_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

   // Sample storage. No reset: contents are meaningless until written, and
   // the full check uses the registered count, so a push in the same cycle
   // as a pop from a full buffer is still dropped.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wptr_q] <= wr_data;
      end
   end

   // Next-state logic for the pacing FSM, pointers and occupancy. In WAIT
   // the pace counter runs and a slot fires on its last value; a slot with
   // data loads the output register and moves to PRESENT, which parks the
   // pace counter at zero until the handshake so the next slot is always a
   // full INTERVAL after the sample was taken.
   always_comb begin
      state_d     = state_q;
      rptr_d      = rptr_q;
      wptr_d      = wptr_q;
      pcnt_d      = pcnt_q;
      rx_valid_d  = rx_valid_q;
      rx_data_d   = rx_data_q;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      pop         = 1'b0;

      push_ok    = wr_en && !full;
      overflow_d = wr_en && full;

      case (state_q)
         ST_WAIT: begin
            if (pcnt_q == PCNT_LAST) begin
               pcnt_d = '0;
               if (count_q != '0) begin
                  pop        = 1'b1;
                  rx_data_d  = mem[rptr_q];
                  rx_valid_d = 1'b1;
                  state_d    = ST_PRESENT;
               end else begin
                  underflow_d = 1'b1;
                  rx_data_d   = '0;
               end
            end else begin
               pcnt_d = pcnt_q + PCNT_W'(1);
            end
         end
         ST_PRESENT: begin
            pcnt_d = '0;
            if (rx_valid_q && rx_ready) begin
               rx_valid_d = 1'b0;
               state_d    = ST_WAIT;
            end
         end
         default: begin
            state_d = ST_WAIT;
         end
      endcase

      if (push_ok) begin
         wptr_d = wptr_q + PTR_W'(1);
      end
      if (pop) begin
         rptr_d = rptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop);
   end

   // State register. Reset clears everything at once, dropping any buffered
   // samples without raising a status pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_WAIT;
         rptr_q      <= '0;
         wptr_q      <= '0;
         pcnt_q      <= '0;
         count_q     <= '0;
         rx_valid_q  <= 1'b0;
         rx_data_q   <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rptr_q      <= rptr_d;
         wptr_q      <= wptr_d;
         pcnt_q      <= pcnt_d;
         count_q     <= count_d;
         rx_valid_q  <= rx_valid_d;
         rx_data_q   <= rx_data_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

endmodule

// File: tb/tb_paced_queue_reader.sv
// ---------------------------------------------------------------------------
// tb_paced_queue_reader
//
// Directed bench for paced_queue_reader with DATA_W=8, DEPTH=4, INTERVAL=2.
// Inputs are driven on the falling edge and outputs sampled there too, so
// every change takes effect at the following rising edge.
// ---------------------------------------------------------------------------
module tb_paced_queue_reader;

   localparam int DATA_W   = 8;
   localparam int DEPTH    = 4;
   localparam int INTERVAL = 2;

   logic              clk;
   logic              rst;
   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              wr_full;
   logic              rx_valid;
   logic [DATA_W-1:0] rx_data;
   logic              rx_ready;
   logic [2:0]        count;
   logic              overflow;
   logic              underflow;

   int num_checks;
   int num_fail;

   logic [DATA_W-1:0] got_q [$];
   int                hs_cyc_q [$];
   int                cyc;
   int                ovf_cnt;
   int                max_cnt;
   bit                full_seen;

   paced_queue_reader #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .INTERVAL (INTERVAL)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .wr_full   (wr_full),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .rx_ready  (rx_ready),
      .count     (count),
      .overflow  (overflow),
      .underflow (underflow)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: records every accepted sample with the cycle it was taken in,
   // and tallies overflow pulses, peak occupancy and whether full was seen.
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (!rst) begin
         if (rx_valid && rx_ready) begin
            got_q.push_back(rx_data);
            hs_cyc_q.push_back(cyc);
         end
         if (overflow) ovf_cnt = ovf_cnt + 1;
         if (int'(count) > max_cnt) max_cnt = int'(count);
         if (wr_full) full_seen = 1'b1;
      end
   end

   // Watchdog so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic applyStimulus(input logic en, input logic [DATA_W-1:0] data,
                                input logic ready);
      wr_en    = en;
      wr_data  = data;
      rx_ready = ready;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      num_checks = num_checks + 1;
      if (observed !== expected) begin
         num_fail = num_fail + 1;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic clearMonitor();
      got_q.delete();
      hs_cyc_q.delete();
      ovf_cnt   = 0;
      max_cnt   = 0;
      full_seen = 1'b0;
   endtask

   // Waits for the monitor to collect n samples, giving up after limit cycles.
   task automatic waitSamples(input string tag, input int n, input int limit);
      int k;
      k = 0;
      while (got_q.size() < n && k < limit) begin
         step();
         k++;
      end
      checkOutput(tag, got_q.size(), n);
   endtask

   initial begin
      logic [DATA_W-1:0] sent [20];
      int                k;
      bit                found;

      num_checks = 0;
      num_fail   = 0;
      cyc        = 0;
      clearMonitor();
      rst = 1'b1;
      applyStimulus(1'b0, '0, 1'b1);

      // Reset state
      repeat (2) step();
      checkOutput("rst_rx_valid",  rx_valid,  0);
      checkOutput("rst_rx_data",   rx_data,   0);
      checkOutput("rst_count",     count,     0);
      checkOutput("rst_wr_full",   wr_full,   0);
      checkOutput("rst_overflow",  overflow,  0);
      checkOutput("rst_underflow", underflow, 0);

      // Idle after reset: slot on every second edge finds the queue empty
      rst = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         step();
         checkOutput($sformatf("idle_underflow_%0d", i), underflow, (i % 2 == 0));
         checkOutput($sformatf("idle_rx_valid_%0d", i), rx_valid, 0);
         checkOutput($sformatf("idle_rx_data_%0d", i), rx_data, 0);
         checkOutput($sformatf("idle_count_%0d", i), count, 0);
      end

      // Three consecutive pushes with downstream always ready. Each
      // handshake is followed by two WAIT cycles and one load, so
      // consecutive handshakes are three cycles apart.
      $display("[TB] three pushes, rx_ready high");
      clearMonitor();
      applyStimulus(1'b1, 8'd10, 1'b1); step();
      applyStimulus(1'b1, 8'd20, 1'b1); step();
      applyStimulus(1'b1, 8'd30, 1'b1); step();
      applyStimulus(1'b0, 8'd0,  1'b1);
      waitSamples("seq3_samples", 3, 30);
      if (got_q.size() == 3) begin
         checkOutput("seq3_data0", got_q[0], 10);
         checkOutput("seq3_data1", got_q[1], 20);
         checkOutput("seq3_data2", got_q[2], 30);
         checkOutput("seq3_gap01", hs_cyc_q[1] - hs_cyc_q[0], 3);
         checkOutput("seq3_gap12", hs_cyc_q[2] - hs_cyc_q[1], 3);
      end
      step();
      checkOutput("seq3_overflow_cnt", ovf_cnt, 0);
      checkOutput("seq3_count_end",    count,   0);
      checkOutput("seq3_rx_valid_end", rx_valid, 0);

      // Six back-to-back pushes with downstream stalled. The first slot
      // with data moves one sample into the output register, then the
      // buffer fills with four more and the sixth push is dropped.
      $display("[TB] six pushes, rx_ready low");
      clearMonitor();
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, 8'h31 + 8'(i), 1'b0);
         step();
      end
      applyStimulus(1'b0, 8'h00, 1'b0);
      repeat (2) step();
      checkOutput("stall_rx_valid",     rx_valid, 1);
      checkOutput("stall_rx_data",      rx_data,  8'h31);
      checkOutput("stall_count",        count,    4);
      checkOutput("stall_wr_full",      wr_full,  1);
      checkOutput("stall_max_count",    max_cnt,  4);
      checkOutput("stall_overflow_cnt", ovf_cnt,  1);
      checkOutput("stall_no_handshake", got_q.size(), 0);
      applyStimulus(1'b0, 8'h00, 1'b1);
      waitSamples("stall_samples", 5, 40);
      if (got_q.size() == 5) begin
         for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("stall_data%0d", i), got_q[i], 8'h31 + 8'(i));
         end
      end
      step();
      checkOutput("stall_count_end", count, 0);

      // Twenty samples, one push every three cycles against a pop every
      // three cycles, so both pointers wrap several times with no drops.
      $display("[TB] twenty samples, pointer wrap");
      clearMonitor();
      for (int i = 0; i < 20; i++) begin
         sent[i] = 8'h40 + 8'(i * 7);
         applyStimulus(1'b1, sent[i], 1'b1);
         step();
         applyStimulus(1'b0, 8'h00, 1'b1);
         repeat (2) step();
      end
      waitSamples("wrap_samples", 20, 40);
      if (got_q.size() == 20) begin
         for (int i = 0; i < 20; i++) begin
            checkOutput($sformatf("wrap_data%0d", i), got_q[i], sent[i]);
         end
      end
      checkOutput("wrap_overflow_cnt", ovf_cnt, 0);
      step();
      checkOutput("wrap_count_end", count, 0);

      // Push landing on the same edge as an empty slot: no bypass, so the
      // slot underflows and the sample comes out at the following slot.
      $display("[TB] push coincident with empty slot");
      clearMonitor();
      found = 1'b0;
      k = 0;
      while (!found && k < 10) begin
         step();
         k++;
         if (underflow) found = 1'b1;
      end
      checkOutput("coin_find_slot", found, 1);
      step();
      applyStimulus(1'b1, 8'h77, 1'b1);
      step();
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("coin_underflow", underflow, 1);
      checkOutput("coin_count",     count,     1);
      checkOutput("coin_rx_valid0", rx_valid,  0);
      step();
      checkOutput("coin_rx_valid1", rx_valid,  0);
      checkOutput("coin_underflow1", underflow, 0);
      step();
      checkOutput("coin_rx_valid2", rx_valid, 1);
      checkOutput("coin_rx_data",   rx_data,  8'h77);
      checkOutput("coin_count_end", count,    0);
      repeat (2) step();

      // Asynchronous reset while a sample is held and two are buffered
      $display("[TB] reset mid-operation");
      clearMonitor();
      applyStimulus(1'b1, 8'h51, 1'b0); step();
      applyStimulus(1'b1, 8'h52, 1'b0); step();
      applyStimulus(1'b1, 8'h53, 1'b0); step();
      applyStimulus(1'b0, 8'h00, 1'b0);
      found = 1'b0;
      k = 0;
      while (!found && k < 10) begin
         if (rx_valid && count == 3'd2) found = 1'b1;
         else begin
            step();
            k++;
         end
      end
      checkOutput("mid_setup", found, 1);
      #2 rst = 1'b1;
      #1;
      checkOutput("mid_rx_valid",  rx_valid,  0);
      checkOutput("mid_rx_data",   rx_data,   0);
      checkOutput("mid_count",     count,     0);
      checkOutput("mid_wr_full",   wr_full,   0);
      checkOutput("mid_overflow",  overflow,  0);
      checkOutput("mid_underflow", underflow, 0);
      step();
      rst = 1'b0;
      applyStimulus(1'b0, 8'h00, 1'b1);
      step();
      checkOutput("post_underflow1", underflow, 0);
      checkOutput("post_rx_valid1",  rx_valid,  0);
      step();
      checkOutput("post_underflow2", underflow, 1);
      checkOutput("post_rx_valid2",  rx_valid,  0);
      checkOutput("post_count",      count,     0);
      checkOutput("post_no_samples", got_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
      $finish;
   end

endmodule
